dmem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: port 0 is the core load/store path and port 1 is the debug/loader path used to preload or inspect data memory.
- Decides the owner every cycle and drives the memory address, write-enable and write-data from the granted port.
- Returns registered read data to the port that issued the read.
- Supports locked bursts, bounded by a hold counter so that neither port starves.

---
 rtl/dmem_arb_pkg.sv | 11 +
 rtl/arb_pick.sv | 28 ++
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: FSM state encoding and port indices.
package dmem_arb_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OWN0 = 2'd1;
   localparam logic [1:0] ST_OWN1 = 2'd2;

   localparam int PORT_CORE = 0;
   localparam int PORT_DBG  = 1;

endpackage

// File: rtl/arb_pick.sv
// Combinational two-way picker: honours the current owner unless a forced switch
// is pending, otherwise resolves by fixed priority or round-robin on last.
module arb_pick #(
   parameter int FIXED_PRIO = 0
) (
   input  logic [1:0] req,
   input  logic       last,
   input  logic       owned,
   input  logic       owner,
   input  logic       force_switch,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (owned && req[owner]) begin
         // force_switch already implies the other port is requesting
         if (force_switch) gnt = owner ? 2'b01 : 2'b10;
         else              gnt = owner ? 2'b10 : 2'b01;
      end else if (req == 2'b11) begin
         if (FIXED_PRIO != 0) gnt = 2'b01;
         else                 gnt = last ? 2'b01 : 2'b10;
      end else begin
         gnt = req;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter (core / debug loader) with locked bursts bounded
// by a hold counter, and registered per-port read return.
//
// state | meaning
// IDLE  | no owner, arbitrate freely
// OWN0  | port 0 holds the lock
// OWN1  | port 1 holds the lock
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DWIDTH     = 32,
   parameter int MAX_HOLD   = 8,
   parameter int FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic              p0_lock,
   input  logic [DWIDTH-1:0] p0_addr,
   input  logic [DWIDTH-1:0] p0_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [DWIDTH-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic              p1_lock,
   input  logic [DWIDTH-1:0] p1_addr,
   input  logic [DWIDTH-1:0] p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DWIDTH-1:0] p1_rdata,
   output logic              core_stall,
   output logic [DWIDTH-1:0] mem_addr,
   output logic              mem_we,
   output logic [DWIDTH-1:0] mem_wdata,
   input  logic [DWIDTH-1:0] mem_rdata
);

   localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

   logic [1:0]        state;
   logic              last;
   logic [7:0]        hold_cnt;
   logic              rd_pend0, rd_pend1;
   logic [DWIDTH-1:0] rdata_q0, rdata_q1;

   logic [1:0] req, pick, gnt;
   logic       owned, owner, other_req, force_switch;
   logic       gnt_any, gnt_port, gnt_lock, gnt_other_req;

   assign req          = {p1_req, p0_req};
   assign owned        = (state == ST_OWN0) || (state == ST_OWN1);
   assign owner        = (state == ST_OWN1);
   assign other_req    = owner ? p0_req : p1_req;
   assign force_switch = owned && other_req && (hold_cnt == HOLD_MAX);

   arb_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
      .req          (req),
      .last         (last),
      .owned        (owned),
      .owner        (owner),
      .force_switch (force_switch),
      .gnt          (pick)
   );

   // Reset kills any grant combinationally so a mid-burst reset never writes
   assign gnt           = rst ? 2'b00 : pick;
   assign gnt_any       = |gnt;
   assign gnt_port      = gnt[PORT_DBG];
   assign gnt_lock      = gnt_port ? p1_lock : p0_lock;
   assign gnt_other_req = gnt_port ? p0_req : p1_req;

   assign p0_gnt     = gnt[PORT_CORE];
   assign p1_gnt     = gnt[PORT_DBG];
   assign core_stall = p0_req & ~gnt[PORT_CORE];
   assign p0_rvalid  = rd_pend0;
   assign p1_rvalid  = rd_pend1;
   assign p0_rdata   = rdata_q0;
   assign p1_rdata   = rdata_q1;

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      if (gnt[PORT_CORE]) begin
         mem_addr  = p0_addr;
         mem_wdata = p0_wdata;
         mem_we    = p0_we;
      end else if (gnt[PORT_DBG]) begin
         mem_addr  = p1_addr;
         mem_wdata = p1_wdata;
         mem_we    = p1_we;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         last     <= 1'b1;
         hold_cnt <= 8'd0;
         rd_pend0 <= 1'b0;
         rd_pend1 <= 1'b0;
         rdata_q0 <= '0;
         rdata_q1 <= '0;
      end else begin
         rd_pend0 <= gnt[PORT_CORE] & ~p0_we;
         rd_pend1 <= gnt[PORT_DBG] & ~p1_we;
         if (gnt[PORT_CORE] && !p0_we) rdata_q0 <= mem_rdata;
         if (gnt[PORT_DBG] && !p1_we)  rdata_q1 <= mem_rdata;
         if (gnt_any) begin
            last  <= gnt_port;
            state <= gnt_lock ? (gnt_port ? ST_OWN1 : ST_OWN0) : ST_IDLE;
            // only a locked re-grant to the same owner under contention extends the hold
            if (owned && (owner == gnt_port) && gnt_lock && gnt_other_req)
               hold_cnt <= (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 8'd1;
            else
               hold_cnt <= 8'd0;
         end else begin
            state    <= ST_IDLE;
            hold_cnt <= 8'd0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a
// cycle-level behavioural model of ownership, hold limit and read return.
module tb_dmem_arbiter;

   localparam int MAXH = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        p0_req, p0_we, p0_lock, p0_gnt, p0_rvalid;
   logic [31:0] p0_addr, p0_wdata, p0_rdata;
   logic        p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
   logic [31:0] p1_addr, p1_wdata, p1_rdata;
   logic        core_stall, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic        f_req0, f_req1, f_gnt0, f_gnt1, f_rv0, f_rv1, f_mwe, f_stall;
   logic [31:0] f_rd0, f_rd1, f_maddr, f_mwd, f_mrd;

   logic [31:0] mem [0:1023];
   assign mem_rdata = mem[mem_addr[11:2]];
   assign f_mrd     = mem[f_maddr[11:2]];

   dmem_arbiter #(.DWIDTH(32), .MAX_HOLD(MAXH), .FIXED_PRIO(0)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr),
      .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr),
      .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .core_stall(core_stall), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   dmem_arbiter #(.DWIDTH(32), .MAX_HOLD(MAXH), .FIXED_PRIO(1)) dut_fp (
      .clk(clk), .rst(rst),
      .p0_req(f_req0), .p0_we(1'b0), .p0_lock(1'b0), .p0_addr(32'h40),
      .p0_wdata(32'h0), .p0_gnt(f_gnt0), .p0_rvalid(f_rv0), .p0_rdata(f_rd0),
      .p1_req(f_req1), .p1_we(1'b0), .p1_lock(1'b0), .p1_addr(32'h44),
      .p1_wdata(32'h0), .p1_gnt(f_gnt1), .p1_rvalid(f_rv1), .p1_rdata(f_rd1),
      .core_stall(f_stall), .mem_addr(f_maddr), .mem_we(f_mwe),
      .mem_wdata(f_mwd), .mem_rdata(f_mrd)
   );

   int checks = 0;
   int errors = 0;

   // model state: owner -1 means nobody holds a lock
   int          m_owner, m_last, m_hold;
   logic        m_rv [2];
   logic [31:0] m_rd [2];

   logic obs_g0, obs_g1, obs_we, obs_stall, obs_f0, obs_f1, obs_fstall;
   logic fp_on;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_owner = -1;
      m_last  = 1;
      m_hold  = 0;
      m_rv[0] = 1'b0; m_rv[1] = 1'b0;
      m_rd[0] = 32'h0; m_rd[1] = 32'h0;
   endtask

   function automatic int m_pick(input logic [1:0] rq);
      if (m_owner >= 0 && rq[m_owner]) begin
         if (rq[1-m_owner] && m_hold == MAXH) return 1 - m_owner;
         return m_owner;
      end
      if (rq == 2'b11) return 1 - m_last;
      if (rq[0]) return 0;
      if (rq[1]) return 1;
      return -1;
   endfunction

   task automatic tick();
      int          g;
      logic [1:0]  rq;
      logic [31:0] ea, ed;
      logic        ewe, lk;
      @(negedge clk);
      rq = {p1_req, p0_req};
      g  = rst ? -1 : m_pick(rq);
      ea = 32'h0; ed = 32'h0; ewe = 1'b0; lk = 1'b0;
      if (g == 0) begin ea = p0_addr; ed = p0_wdata; ewe = p0_we; lk = p0_lock; end
      if (g == 1) begin ea = p1_addr; ed = p1_wdata; ewe = p1_we; lk = p1_lock; end
      chk("gnt0", p0_gnt, g == 0);
      chk("gnt1", p1_gnt, g == 1);
      chk("mem_we", mem_we, ewe);
      chk("mem_addr", mem_addr, ea);
      chk("mem_wdata", mem_wdata, ed);
      chk("core_stall", core_stall, p0_req && g != 0);
      chk("rvalid0", p0_rvalid, m_rv[0]);
      chk("rvalid1", p1_rvalid, m_rv[1]);
      chk("rdata0", p0_rdata, m_rd[0]);
      chk("rdata1", p1_rdata, m_rd[1]);
      if (fp_on) begin
         chk("fp_gnt0", f_gnt0, f_req0 & ~rst);
         chk("fp_gnt1", f_gnt1, f_req1 & ~f_req0 & ~rst);
         chk("fp_stall", f_stall, f_req0 & rst);
      end
      obs_g0 = p0_gnt; obs_g1 = p1_gnt; obs_we = mem_we; obs_stall = core_stall;
      obs_f0 = f_gnt0; obs_f1 = f_gnt1; obs_fstall = f_stall;
      if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
      if (rst) begin
         m_reset();
      end else begin
         m_rv[0] = 1'b0; m_rv[1] = 1'b0;
         if (g >= 0) begin
            if (g == m_owner && lk && rq[1-g]) m_hold = (m_hold + 1 > MAXH) ? MAXH : m_hold + 1;
            else m_hold = 0;
            m_owner = lk ? g : -1;
            m_last  = g;
            if (!ewe) begin m_rv[g] = 1'b1; m_rd[g] = mem[ea[11:2]]; end
         end else begin
            m_owner = -1;
            m_hold  = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      p0_req = 0; p0_we = 0; p0_lock = 0; p0_addr = 0; p0_wdata = 0;
      p1_req = 0; p1_we = 0; p1_lock = 0; p1_addr = 0; p1_wdata = 0;
   endtask

   initial begin
      int k, n, run;
      logic seen0, prev0;
      fp_on = 1'b0; f_req0 = 0; f_req1 = 0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[32'h10 >> 2] = 32'hDEADBEEF;
      idle_inputs();
      rst = 1'b1;
      m_reset();
      @(posedge clk); #1;
      tick(); tick();

      // T1: port 0 read after reset
      rst = 1'b0;
      p0_req = 1; p0_addr = 32'h10;
      tick();
      chk("t1_gnt", obs_g0, 1);
      p0_req = 0;
      chk("t1_rvalid", p0_rvalid, 1);
      chk("t1_rdata", p0_rdata, 32'hDEADBEEF);
      chk("t1_p1rv", p1_rvalid, 0);
      tick();

      // T2: round-robin under contention
      rst = 1'b1; tick(); rst = 1'b0;
      p0_req = 1; p0_addr = 32'h14; p1_req = 1; p1_addr = 32'h18;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t2_g0", obs_g0, (i % 2) == 0);
         chk("t2_stall", obs_stall, (i % 2) == 1);
      end
      idle_inputs(); tick();

      // T3: locked 20-write burst from port 1 against continuous port 0 reads
      p1_req = 1; p1_we = 1; p1_lock = 1;
      k = 0; n = 0; run = 0; seen0 = 0; prev0 = 0;
      while (k < 20 && n < 100) begin
         p1_addr = 32'h100 + 32'(4 * k); p1_wdata = 32'(k);
         tick();
         n++;
         p0_req = 1; p0_addr = 32'h200;
         if (prev0 && seen0 && run >= 0) begin
            chk("t3_resume", obs_g1, 1);
            run = -1;
         end
         if (obs_g1) begin k++; if (!seen0) run++; end
         if (obs_g0 && !seen0) begin seen0 = 1; chk("t3_run", run, 9); end
         prev0 = obs_g0;
      end
      chk("t3_done", k, 20);
      idle_inputs(); tick(); tick();
      for (int j = 0; j < 20; j++) chk("t3_mem", mem[64 + j], j);

      // T4: write then read-back through the other port
      p1_req = 1; p1_we = 1; p1_addr = 32'h20; p1_wdata = 32'h55;
      tick();
      chk("t4_wgnt", obs_g1, 1);
      chk("t4_norv", p1_rvalid, 0);
      idle_inputs();
      p0_req = 1; p0_addr = 32'h20;
      tick();
      chk("t4_rvalid", p0_rvalid, 1);
      chk("t4_rdata", p0_rdata, 32'h55);
      idle_inputs(); tick();

      // T5: reset in the middle of a port 1 locked burst
      p1_req = 1; p1_we = 1; p1_lock = 1; p1_addr = 32'h300; p1_wdata = 32'hAA;
      tick();
      p1_wdata = 32'hBB;
      rst = 1'b1;
      tick();
      chk("t5_we", obs_we, 0);
      chk("t5_g0", obs_g0, 0);
      chk("t5_g1", obs_g1, 0);
      chk("t5_mem", mem[32'h300 >> 2], 32'hAA);
      rst = 1'b0;
      p0_req = 1; p0_addr = 32'h10;
      tick();
      chk("t5_first", obs_g0, 1);
      idle_inputs(); tick();

      // T6: fixed priority instance
      fp_on = 1'b1; f_req0 = 1; f_req1 = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t6_g0", obs_f0, 1);
         chk("t6_g1", obs_f1, 0);
         chk("t6_stall", obs_fstall, 0);
      end
      f_req0 = 0;
      tick();
      chk("t6_p1alone", obs_f1, 1);
      f_req1 = 0; fp_on = 1'b0;

      // random traffic; core side keeps its request stable until granted
      for (int c = 0; c < 600; c++) begin
         rst = ($urandom_range(0, 59) == 0);
         if (!(p0_req && !obs_g0)) begin
            p0_req   = ($urandom_range(0, 3) != 0);
            p0_we    = $urandom_range(0, 1) == 1;
            p0_lock  = ($urandom_range(0, 7) != 0);
            p0_addr  = 32'($urandom_range(0, 63)) << 2;
            p0_wdata = $urandom;
         end
         p1_req   = ($urandom_range(0, 3) != 0);
         p1_we    = $urandom_range(0, 1) == 1;
         p1_lock  = ($urandom_range(0, 7) != 0);
         p1_addr  = 32'($urandom_range(0, 63)) << 2;
         p1_wdata = $urandom;
         tick();
      end
      rst = 1'b0;
      idle_inputs(); tick(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
